// File: rtl/uart_receiver_if.sv
// Consumer-side bundle of the UART receiver: received byte, its valid/ready
// handshake and the two error pulses.
interface uart_receiver_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a mid-bit sampling FSM and a one-byte holding
// register that reports frame errors and overruns as single-cycle pulses.
module uart_receiver #(
  parameter int clk_divider = 200
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_uart_rx,
  uart_receiver_if.master rx_if
);

`ifdef BENCH
  localparam int PERIOD = 4;
`else
  localparam int PERIOD = clk_divider;
`endif
  localparam int CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_q, done_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic rx_s;
  logic tick;

  assign rx_s = sync_q[1];
  assign tick = (baud_q == '0);

  // NOTE: every variable gets its default before the case statement so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    sync_d      = {sync_q[0], i_uart_rx};
    state_d     = state_q;
    baud_d      = baud_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          baud_d  = HALF_LOAD;
        end
      end
      S_START, S_DATA, S_STOP: begin
        baud_d = tick ? FULL_LOAD : baud_q - CNT_W'(1);
        if (tick) begin
          unique case (state_q)
            S_START: begin
              // A start bit that is high again at mid-bit was a glitch.
              if (rx_s) begin
                state_d = S_IDLE;
              end else begin
                state_d   = S_DATA;
                bit_cnt_d = 3'd0;
              end
            end
            S_DATA: begin
              shift_d[bit_cnt_q] = rx_s;
              if (bit_cnt_q == 3'd7) state_d = S_STOP;
              else                   bit_cnt_d = bit_cnt_q + 3'd1;
            end
            default: begin
              // Leaving mid-stop-bit lets a back-to-back start edge be seen.
              if (rx_s) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                frame_err_d = 1'b1;
                state_d     = S_WAIT_HIGH;
              end
            end
          endcase
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a completed byte is taken one cycle after the stop sample.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (done_q) begin
      if (!valid_q || rx_if.i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_if.i_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      baud_q      <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      done_q      <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      baud_q      <= baud_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = frame_err_q;
  assign rx_if.o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a serial-line driver queues the expected
// events per frame and an independent monitor matches what the DUT presents.
module tb_uart_receiver;

`ifdef BENCH
  localparam int BIT = 4;
`else
  localparam int BIT = 16;
`endif
  localparam int GLITCH = (BIT * 5) / 16;

  typedef enum int {EV_BYTE, EV_FERR, EV_OVR} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
    int         exp_cyc;
  } ev_t;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_uart_rx;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  sb[$];

  uart_receiver_if rx_if ();

  uart_receiver #(.clk_divider(16)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_uart_rx(i_uart_rx),
    .rx_if    (rx_if)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_e k, input logic [7:0] d, input int exp_cyc);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.exp_cyc = exp_cyc;
    sb.push_back(e);
  endtask

  // Line driver: called at posedge+1, leaves the line at v for n cycles.
  task automatic hold(input logic v, input int n);
    i_uart_rx = v;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop_bit, BIT);
  endtask

  task automatic observe(input ev_e k, input logic [7:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind=%0d data=0x%0h, expected none (cycle %0d)",
               k, d, cyc);
    end else begin
      e = sb.pop_front();
      check("event_kind", k, e.kind);
      if (k == EV_BYTE) begin
        check("byte_data", d, e.data);
        if (e.exp_cyc >= 0) check("byte_latency", cyc, e.exp_cyc);
      end
    end
  endtask

  // Monitor: each presented event must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (rx_if.o_frame_err || rx_if.o_overrun)
        check("ferr_ovr_exclusive", rx_if.o_frame_err & rx_if.o_overrun, 0);
      if (rx_if.o_frame_err) observe(EV_FERR, 8'h00);
      if (rx_if.o_overrun)   observe(EV_OVR, 8'h00);
      if (rx_if.o_valid && rx_if.i_ready) observe(EV_BYTE, rx_if.o_data);
    end
  end

  initial begin
    i_rst = 1'b1;
    i_uart_rx = 1'b1;
    rx_if.i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_data", rx_if.o_data, 8'h00);
    check("reset_valid", rx_if.o_valid, 0);
    check("reset_frame_err", rx_if.o_frame_err, 0);
    check("reset_overrun", rx_if.o_overrun, 0);
    i_rst = 1'b0;
    hold(1'b1, 2 * BIT);

    // Single frame with timed delivery
    push(EV_BYTE, 8'h55, cyc + 3 + BIT / 2 + 9 * BIT + 1);
    send(8'h55, 1'b1);
    hold(1'b1, 2 * BIT);

    // Overrun: consumer stalled across two back-to-back frames
    rx_if.i_ready = 1'b0;
    push(EV_OVR, 8'h00, -1);
    push(EV_BYTE, 8'hA3, -1);
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    hold(1'b1, 2 * BIT);
    check("ovr_valid_held", rx_if.o_valid, 1);
    check("ovr_data_retained", rx_if.o_data, 8'hA3);
    rx_if.i_ready = 1'b1;
    hold(1'b1, 2);
    check("ovr_valid_dropped", rx_if.o_valid, 0);
    check("ovr_data_kept", rx_if.o_data, 8'hA3);

    // Glitch shorter than half a bit, then a real frame
    hold(1'b0, GLITCH);
    hold(1'b1, 2 * BIT);
    check("glitch_no_valid", rx_if.o_valid, 0);
    push(EV_BYTE, 8'h81, -1);
    send(8'h81, 1'b1);
    hold(1'b1, 2 * BIT);

    // Frame error with line stuck low, then recovery
    push(EV_FERR, 8'h00, -1);
    send(8'h3C, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 2 * BIT);
    push(EV_BYTE, 8'h7E, -1);
    send(8'h7E, 1'b1);
    hold(1'b1, 2 * BIT);

    // Reset during data bit 4 of 0xFF
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT);
    hold(1'b1, BIT / 2);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("midreset_data", rx_if.o_data, 8'h00);
    check("midreset_valid", rx_if.o_valid, 0);
    check("midreset_flags", {rx_if.o_frame_err, rx_if.o_overrun}, 0);
    hold(1'b1, 12 * BIT);
    check("midreset_no_valid", rx_if.o_valid, 0);
    push(EV_BYTE, 8'h12, -1);
    send(8'h12, 1'b1);
    hold(1'b1, 2 * BIT);

    // Randomized frames, gaps and bad stop bits
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int gap;
      b = 8'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 3 * BIT));
      if ($urandom_range(0, 5) == 0) begin
        push(EV_FERR, 8'h00, -1);
        send(b, 1'b0);
        hold(1'b0, int'($urandom_range(0, 2 * BIT)));
        hold(1'b1, BIT + gap);
      end else begin
        push(EV_BYTE, b, -1);
        send(b, 1'b1);
        if (gap > 0) hold(1'b1, gap);
      end
    end
    hold(1'b1, 2 * BIT);

    // Loopback stream 0x00..0xFF, back to back
    for (int v = 0; v < 256; v++) begin
      push(EV_BYTE, 8'(v), -1);
      send(8'(v), 1'b1);
    end
    hold(1'b1, 2 * BIT);

    for (int i = 0; i < 20 * BIT && sb.size() != 0; i++) @(posedge i_clk);
    #1;
    check("scoreboard_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
